// File: rtl/button_scan_pkg.sv
// Shared types and width helpers for the push-button shift-register scanner.
package button_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CLK_HIGH,
        CLK_LOW,
        COMPARE
    } scan_state_t;

    function automatic int timer_width(input int scan_gap, input int clk_div);
        return $clog2(((scan_gap > clk_div) ? scan_gap : clk_div) + 1);
    endfunction

    function automatic int index_width(input int num_bits);
        return (num_bits > 1) ? $clog2(num_bits) : 1;
    endfunction

    function automatic int count_width(input int stable_scans);
        return $clog2(stable_scans + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, reset to 0.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_shift_scanner.sv
// Scans buttons through an external PISO shift register, MSB first, and
// debounces by requiring STABLE_SCANS identical consecutive scans.
//   state    | meaning
//   IDLE     | gap between scans, load high, clock low
//   LOAD     | parallel load pulse (shift_load low)
//   SETTLE   | load released, first bit sampled at the end
//   CLK_HIGH | shift clock high half-period
//   CLK_LOW  | shift clock low half-period, next bit sampled at the end
//   COMPARE  | one cycle: debounce update, scan_done
module button_shift_scanner
    import button_scan_pkg::*;
#(
    parameter int NUM_BITS     = 16,
    parameter int CLK_DIV      = 16,
    parameter int SCAN_GAP     = 1000,
    parameter int STABLE_SCANS = 3,
    parameter int INVERT       = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                shift_out,
    output logic                shift_clkin,
    output logic                shift_load,
    output logic [NUM_BITS-1:0] buttons,
    output logic                buttons_changed,
    output logic                scan_done
);

    localparam int TW = timer_width(SCAN_GAP, CLK_DIV);
    localparam int IW = index_width(NUM_BITS);
    localparam int CW = count_width(STABLE_SCANS);

    localparam logic [TW-1:0] GAP_LAST   = TW'(SCAN_GAP - 1);
    localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_TOP    = IW'(NUM_BITS - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_SCANS);
    localparam logic          INV_BIT    = (INVERT != 0);

    scan_state_t         state;
    scan_state_t         next_state;
    logic [TW-1:0]       timer;
    logic                timer_done;
    logic [IW-1:0]       bit_idx;
    logic [NUM_BITS-1:0] scan;
    logic [NUM_BITS-1:0] candidate;
    logic [CW-1:0]       stable_cnt;
    logic [NUM_BITS-1:0] next_cand;
    logic [CW-1:0]       next_cnt;
    logic                update;
    logic                sync_bit;
    logic                sample_bit;

    sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (shift_out),
        .q     (sync_bit)
    );

    assign sample_bit = sync_bit ^ INV_BIT;

    always_comb begin
        timer_done = 1'b0;
        case (state)
            IDLE:    timer_done = (timer == GAP_LAST);
            COMPARE: timer_done = 1'b1;
            default: timer_done = (timer == DIV_LAST);
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (timer_done) next_state = LOAD;
            LOAD:     if (timer_done) next_state = SETTLE;
            SETTLE:   if (timer_done) next_state = CLK_HIGH;
            CLK_HIGH: if (timer_done) next_state = CLK_LOW;
            CLK_LOW: begin
                if (timer_done) next_state = (bit_idx == '0) ? COMPARE : CLK_HIGH;
            end
            COMPARE:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            timer <= timer_done ? '0 : timer + 1'b1;
        end
    end

    // Registered pin drivers so the board never sees decode glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_load  <= 1'b1;
            shift_clkin <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            shift_load  <= (next_state != LOAD);
            shift_clkin <= (next_state == CLK_HIGH);
            scan_done   <= (next_state == COMPARE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan    <= '0;
            bit_idx <= '0;
        end else if (state == SETTLE && timer_done) begin
            scan[NUM_BITS-1] <= sample_bit;
            bit_idx          <= IDX_TOP - 1'b1;
        end else if (state == CLK_LOW && timer_done) begin
            scan[bit_idx] <= sample_bit;
            if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
        end
    end

    always_comb begin
        next_cand = candidate;
        next_cnt  = stable_cnt;
        if (scan == candidate) begin
            next_cnt = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
        end else begin
            next_cand = scan;
            next_cnt  = CW'(1);
        end
        update = (state == COMPARE) && (next_cnt == STABLE_MAX) && (next_cand != buttons);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            candidate       <= '0;
            stable_cnt      <= '0;
            buttons         <= '0;
            buttons_changed <= 1'b0;
        end else begin
            buttons_changed <= update;
            if (state == COMPARE) begin
                candidate  <= next_cand;
                stable_cnt <= next_cnt;
            end
            if (update) buttons <= next_cand;
        end
    end

endmodule

// File: tb/tb_button_shift_scanner.sv
// Scoreboard bench: a shift-register pin model feeds the scanner, a debounce
// reference predicts each scan's result and a monitor checks it at scan_done.
module tb_button_shift_scanner;

    localparam int NB     = 16;
    localparam int CD     = 16;
    localparam int GAP    = 1000;
    localparam int ST     = 3;
    localparam int INV    = 1;
    localparam int PERIOD = GAP + 2 * CD + (NB - 1) * 2 * CD + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          shift_out;
    logic          shift_clkin;
    logic          shift_load;
    logic [NB-1:0] buttons;
    logic          buttons_changed;
    logic          scan_done;

    button_shift_scanner #(
        .NUM_BITS     (NB),
        .CLK_DIV      (CD),
        .SCAN_GAP     (GAP),
        .STABLE_SCANS (ST),
        .INVERT       (INV)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .shift_out       (shift_out),
        .shift_clkin     (shift_clkin),
        .shift_load      (shift_load),
        .buttons         (buttons),
        .buttons_changed (buttons_changed),
        .scan_done       (scan_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NB-1:0] btn;
        logic          chg;
    } exp_t;

    exp_t          exp_q[$];
    logic [NB-1:0] raw_q[$];
    logic [NB-1:0] raw_cur = 16'hFFFF;
    logic [NB-1:0] hist[$];
    logic [NB-1:0] mdl_buttons = '0;
    logic [NB-1:0] sr = 16'hFFFF;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output follows a value once it has been seen in ST consecutive scans.
    task automatic model_scan(input logic [NB-1:0] raw);
        logic [NB-1:0] s;
        logic          same;
        exp_t          e;
        s = (INV != 0) ? ~raw : raw;
        hist.push_back(s);
        if (hist.size() > ST) void'(hist.pop_front());
        e.chg = 1'b0;
        if (hist.size() == ST) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != s) same = 1'b0;
            if (same && s != mdl_buttons) begin
                mdl_buttons = s;
                e.chg = 1'b1;
            end
        end
        e.btn = mdl_buttons;
        exp_q.push_back(e);
    endtask

    assign shift_out = sr[NB-1];

    // External PISO register: parallel load on load low, shift on clock rise.
    always @(negedge shift_load or posedge shift_clkin) begin
        if (!shift_load) begin
            if (raw_q.size() > 0) raw_cur = raw_q.pop_front();
            sr = raw_cur;
            model_scan(raw_cur);
        end else begin
            sr = {sr[NB-2:0], 1'b1};
        end
    end

    logic          pend = 1'b0;
    logic [NB-1:0] last_b = '0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            pend   = 1'b0;
            last_b = '0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: scan_done with no expected entry (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("buttons", 32'(buttons), 32'(e.btn));
                    check("buttons_changed", 32'(buttons_changed), 32'(e.chg));
                end
                pend = 1'b0;
            end else if (buttons_changed || buttons !== last_b) begin
                total++;
                bad++;
                $display("FAIL spurious_update: buttons=%0h changed=%0b outside scan end", buttons, buttons_changed);
            end
            last_b = buttons;
            if (scan_done) pend = 1'b1;
        end
    end

    int   load_cnt = 0, run_len = 0, edge_cnt = 0, overlap = 0, cyc_since = 0;
    bit   have_prev = 0;
    logic prev_clk = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            load_cnt  = 0;
            run_len   = 0;
            edge_cnt  = 0;
            overlap   = 0;
            cyc_since = 0;
            have_prev = 0;
            prev_clk  = 1'b0;
        end else begin
            cyc_since++;
            if (!shift_load) load_cnt++;
            if (shift_clkin && !shift_load) overlap++;
            if (shift_clkin) begin
                if (!prev_clk) edge_cnt++;
                run_len++;
            end else if (prev_clk) begin
                check("clk_high_len", run_len, CD);
                run_len = 0;
            end
            prev_clk = shift_clkin;
            if (scan_done) begin
                check("load_low_cycles", load_cnt, CD);
                check("rising_edges", edge_cnt, NB - 1);
                check("clk_high_during_load", overlap, 0);
                if (have_prev) check("scan_period", cyc_since, PERIOD);
                have_prev = 1;
                cyc_since = 0;
                load_cnt  = 0;
                edge_cnt  = 0;
                overlap   = 0;
            end
        end
    end

    task automatic wait_scans(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < n * PERIOD + 200) begin
            @(negedge clock);
            cyc++;
            if (scan_done) seen++;
        end
        check("scan_done_timeout", seen, n);
        @(negedge clock);
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        exp_q.delete();
        hist.delete();
        mdl_buttons = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clkin"}, 32'(shift_clkin), 0);
        check({tag, "_load"}, 32'(shift_load), 1);
        check({tag, "_buttons"}, 32'(buttons), 0);
        check({tag, "_changed"}, 32'(buttons_changed), 0);
        check({tag, "_scan_done"}, 32'(scan_done), 0);
    endtask

    initial begin
        logic [NB-1:0] pats[4];
        int            n;
        int            n_rand;
        int            run;
        logic [NB-1:0] p;

        pats[0] = 16'hFFFE;
        pats[1] = 16'h7FFF;
        pats[2] = 16'h5AA5;
        pats[3] = 16'hFFFF;

        #1 assert_reset();
        #1 check_reset_outputs("init_reset");
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        wait_scans(3);
        check("idle_all_released", 32'(buttons), 0);

        raw_q.push_back(16'hFFFE);
        wait_scans(3);
        check("single_press_bit0", 32'(buttons), 32'h0001);

        raw_q.push_back(16'h7FFF);
        wait_scans(3);
        check("msb_first_bit15", 32'(buttons), 32'h8000);

        raw_q.push_back(16'hFFFE);
        raw_q.push_back(16'hFFFF);
        raw_q.push_back(16'hFFFE);
        raw_q.push_back(16'hFFFE);
        raw_q.push_back(16'hFFFE);
        wait_scans(4);
        check("bounce_held_off", 32'(buttons), 32'h8000);
        wait_scans(1);
        check("bounce_settled", 32'(buttons), 32'h0001);

        n = 0;
        while (edge_cnt < 8 && n < 3 * PERIOD) begin
            @(negedge clock);
            n++;
        end
        check("reach_8th_clk_high", (edge_cnt >= 8) ? 1 : 0, 1);
        repeat (3) @(negedge clock);
        check("pre_reset_buttons", 32'(buttons), 32'h0001);
        #2 assert_reset();
        #1 check_reset_outputs("mid_scan_reset");
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (shift_load && n < 3 * GAP);
        check("gap_after_reset", n, GAP);
        wait_scans(3);
        check("requalify_after_reset", 32'(buttons), 32'h0001);

        raw_q.push_back(16'hFFFF);
        wait_scans(3);
        check("release", 32'(buttons), 0);

        n_rand = 0;
        while (n_rand < 12) begin
            p   = pats[$urandom_range(0, 3)];
            run = $urandom_range(1, 4);
            for (int i = 0; i < run; i++) raw_q.push_back(p);
            n_rand += run;
        end
        wait_scans(n_rand + 1);
        check("random_final", 32'(buttons), 32'(mdl_buttons));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
